// File: rtl/vga_bounce_gen_pkg.sv
// Shared constants and types for the bouncing-square pixel generator.
// Mirrors the VGA timing header values used by the sync block.
package vga_bounce_gen_pkg;

    localparam int H_DISPLAY    = 640;
    localparam int V_DISPLAY    = 480;
    localparam int H_TOTAL      = 800;
    localparam int V_TOTAL      = 525;
    localparam int REFRESH_LINE = 481;
    localparam int RGB_W        = 12;

    // Per-axis motion direction.
    typedef enum logic {
        AXIS_INC = 1'b0,
        AXIS_DEC = 1'b1
    } axis_state_t;

endpackage

// File: rtl/vga_bounce_axis.sv
// One axis of square motion: position register plus INC/DEC bounce FSM.
//
//   state    | meaning
//   ---------+---------------------------------------------
//   AXIS_INC | moving toward MAX, stepping +VEL per refresh
//   AXIS_DEC | moving toward MIN, stepping -VEL per refresh
//
// bounce is a combinational pulse, high on the step that clamps to a limit.
module vga_bounce_axis
    import vga_bounce_gen_pkg::*;
#(
    parameter int MIN  = 0,
    parameter int MAX  = 640,
    parameter int SIZE = 32,
    parameter int VEL  = 2
) (
    input  logic       clk_100MHz,
    input  logic       rst,
    input  logic       step,
    output logic [9:0] pos,
    output logic       bounce
);

    // 11-bit arithmetic so pos+VEL cannot wrap.
    localparam logic [10:0] HI_LIM  = 11'(MAX - SIZE);
    localparam logic [10:0] LO_LIM  = 11'(MIN + VEL);
    localparam logic [10:0] VEL_11  = 11'(VEL);
    localparam logic [9:0]  VEL_10  = 10'(VEL);
    localparam logic [9:0]  MIN_POS = 10'(MIN);

    axis_state_t state_q, state_d;
    logic [9:0]  pos_d;
    logic [10:0] pos_ext, pos_inc;
    logic [9:0]  pos_dec;

    assign pos_ext = {1'b0, pos};
    assign pos_inc = pos_ext + VEL_11;
    assign pos_dec = pos - VEL_10;

    // State and position registers; only move when step is asserted.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            state_q <= AXIS_INC;
            pos     <= MIN_POS;
        end else begin
            state_q <= state_d;
            pos     <= pos_d;
        end
    end

    // Next position, direction and bounce pulse.
    always_comb begin
        state_d = state_q;
        pos_d   = pos;
        bounce  = 1'b0;
        if (step) begin
            case (state_q)
                AXIS_INC: begin
                    if (pos_inc >= HI_LIM) begin
                        pos_d   = HI_LIM[9:0];
                        state_d = AXIS_DEC;
                        bounce  = 1'b1;
                    end else begin
                        pos_d = pos_inc[9:0];
                    end
                end
                AXIS_DEC: begin
                    if (pos_ext <= LO_LIM) begin
                        pos_d   = MIN_POS;
                        state_d = AXIS_INC;
                        bounce  = 1'b1;
                    end else begin
                        pos_d = pos_dec;
                    end
                end
                default: begin
                    state_d = AXIS_INC;
                end
            endcase
        end
    end

endmodule

// File: rtl/vga_bounce_gen.sv
// Bouncing-square pixel generator behind the 640x480 VGA sync block.
// Optional border selected with macro VGA_BOUNCE_BORDER_EN; without it the
// square bounces off the full display edges and no border is drawn.
// rgb is registered to line up with the sync block's buffered hsync/vsync.
module vga_bounce_gen
    import vga_bounce_gen_pkg::*;
#(
    parameter int          SQ_SIZE    = 32,
    parameter int          X_VEL      = 2,
    parameter int          Y_VEL      = 1,
    parameter logic [11:0] FG_RGB     = 12'hF00,
    parameter logic [11:0] BG_RGB     = 12'h000,
    parameter int          BORDER_W   = 8,
    parameter logic [11:0] BORDER_RGB = 12'hFFF
) (
    input  logic             clk_100MHz,
    input  logic             rst,
    input  logic             pixel_tick,
    input  logic             video,
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    input  logic             pause,
    output logic [RGB_W-1:0] rgb,
    output logic [7:0]       bounce_cnt
);

`ifdef VGA_BOUNCE_BORDER_EN
    localparam int EDGE_W = BORDER_W;
`else
    localparam int EDGE_W = 0;
`endif

    localparam logic [10:0] SQ_W = 11'(SQ_SIZE);

    logic             refresh, step;
    logic [9:0]       sq_x, sq_y;
    logic             bounce_x, bounce_y;
    logic [10:0]      px, py, sx, sy;
    logic             hit;
    logic             border;
    logic [RGB_W-1:0] rgb_next;

    // One clock per frame, inside vertical blank.
    assign refresh = pixel_tick && (pixel_x == 10'd0) && (pixel_y == 10'(REFRESH_LINE));
    assign step    = refresh && !pause;

    vga_bounce_axis #(
        .MIN  (EDGE_W),
        .MAX  (H_DISPLAY - EDGE_W),
        .SIZE (SQ_SIZE),
        .VEL  (X_VEL)
    ) u_axis_x (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .step       (step),
        .pos        (sq_x),
        .bounce     (bounce_x)
    );

    vga_bounce_axis #(
        .MIN  (EDGE_W),
        .MAX  (V_DISPLAY - EDGE_W),
        .SIZE (SQ_SIZE),
        .VEL  (Y_VEL)
    ) u_axis_y (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .step       (step),
        .pos        (sq_y),
        .bounce     (bounce_y)
    );

    assign px  = {1'b0, pixel_x};
    assign py  = {1'b0, pixel_y};
    assign sx  = {1'b0, sq_x};
    assign sy  = {1'b0, sq_y};
    assign hit = (px >= sx) && (px < sx + SQ_W) && (py >= sy) && (py < sy + SQ_W);

`ifdef VGA_BOUNCE_BORDER_EN
    // Frame of BORDER_W pixels around the visible area.
    always_comb begin
        border = (px < 11'(BORDER_W)) || (px >= 11'(H_DISPLAY - BORDER_W)) ||
                 (py < 11'(BORDER_W)) || (py >= 11'(V_DISPLAY - BORDER_W));
    end
`else
    logic unused_border_cfg;
    assign unused_border_cfg = ^{BORDER_RGB, 11'(BORDER_W)};
    assign border            = 1'b0;
`endif

    // Colour priority: blanking, border, square, background.
    always_comb begin
        rgb_next = BG_RGB;
        if (!video) begin
            rgb_next = '0;
        end else if (border) begin
`ifdef VGA_BOUNCE_BORDER_EN
            rgb_next = BORDER_RGB;
`else
            rgb_next = BG_RGB;
`endif
        end else if (hit) begin
            rgb_next = FG_RGB;
        end
    end

    // Output colour register, one clock behind the coordinates.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            rgb <= '0;
        end else begin
            rgb <= rgb_next;
        end
    end

    // Count frames with any bounce; a corner hit counts once.
    always_ff @(posedge clk_100MHz or posedge rst) begin
        if (rst) begin
            bounce_cnt <= 8'd0;
        end else if (bounce_x || bounce_y) begin
            bounce_cnt <= bounce_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_vga_bounce_gen.sv
// Bench for vga_bounce_gen: the driver places coordinates directly (jumping
// the sync counters) and queues expected outputs; a monitor pops and compares
// one clock later. Reference model tracks square position/direction as ints.
module tb_vga_bounce_gen;

    localparam int SQ = 32;
`ifdef VGA_BOUNCE_BORDER_EN
    localparam int EDGE = 8;
`else
    localparam int EDGE = 0;
`endif

    logic       clk_100MHz = 1'b0;
    logic       rst;
    logic       pixel_tick;
    logic       video;
    logic [9:0] pixel_x;
    logic [9:0] pixel_y;
    logic       pause;
    logic [11:0] rgb;
    logic [7:0]  bounce_cnt;

    vga_bounce_gen dut (
        .clk_100MHz (clk_100MHz),
        .rst        (rst),
        .pixel_tick (pixel_tick),
        .video      (video),
        .pixel_x    (pixel_x),
        .pixel_y    (pixel_y),
        .pause      (pause),
        .rgb        (rgb),
        .bounce_cnt (bounce_cnt)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    int n_checks = 0;
    int n_fail   = 0;
    logic req = 1'b0;

    logic [11:0] exp_q[$];
    bit          kind_q[$];
    string       name_q[$];

    // Reference model state.
    int m_x, m_y, m_dx, m_dy, m_cnt;

    task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %03h expected %03h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_x = EDGE; m_y = EDGE; m_dx = 1; m_dy = 1; m_cnt = 0;
    endtask

    task automatic step_axis(inout int p, inout int d, input int lo, input int hi, input int vel,
                             output bit b);
        int far;
        far = hi - SQ;
        b = 1'b0;
        if (d > 0) begin
            if (p + vel >= far) begin p = far; d = -1; b = 1'b1; end
            else p = p + vel;
        end else begin
            if (p - vel <= lo) begin p = lo; d = 1; b = 1'b1; end
            else p = p - vel;
        end
    endtask

    function automatic logic [11:0] exp_rgb(input int x, input int y, input bit vid);
        if (!vid) return 12'h000;
`ifdef VGA_BOUNCE_BORDER_EN
        if (x < EDGE || x >= 640 - EDGE || y < EDGE || y >= 480 - EDGE) return 12'hFFF;
`endif
        if (x >= m_x && x < m_x + SQ && y >= m_y && y < m_y + SQ) return 12'hF00;
        return 12'h000;
    endfunction

    task automatic drive(input int x, input int y, input bit vid, input bit tick, input bit kind,
                         input logic [11:0] e, input string nm);
        @(negedge clk_100MHz);
        pixel_x = 10'(x); pixel_y = 10'(y); video = vid; pixel_tick = tick; req = 1'b1;
        exp_q.push_back(e); kind_q.push_back(kind); name_q.push_back(nm);
    endtask

    task automatic go_idle(input int n);
        repeat (n) begin
            @(negedge clk_100MHz);
            req = 1'b0; pixel_tick = 1'b0; pixel_x = 10'd700; pixel_y = 10'd500; video = 1'b0;
        end
    endtask

    task automatic probe(input int x, input int y, input bit vid, input string nm);
        drive(x, y, vid, 1'b0, 1'b0, exp_rgb(x, y, vid), nm);
    endtask

    task automatic probe_lit(input int x, input int y, input logic [11:0] e, input string nm);
        drive(x, y, 1'b1, 1'b0, 1'b0, e, nm);
    endtask

    task automatic cnt_lit(input logic [7:0] e, input string nm);
        drive(700, 500, 1'b0, 1'b0, 1'b1, {4'h0, e}, nm);
    endtask

    // A tick at (0,481) followed by three quiet clocks: one frame boundary.
    task automatic refresh();
        bit bx, by;
        if (!pause) begin
            step_axis(m_x, m_dx, EDGE, 640 - EDGE, 2, bx);
            step_axis(m_y, m_dy, EDGE, 480 - EDGE, 1, by);
            if (bx || by) m_cnt = (m_cnt + 1) % 256;
        end
        drive(0, 481, 1'b0, 1'b1, 1'b1, 12'(m_cnt), "bounce_cnt");
        go_idle(3);
    endtask

    task automatic probe_edges();
        probe(m_x, m_y, 1'b1, "sq_tl");
        if (m_x > 0) probe(m_x - 1, m_y, 1'b1, "sq_left_out");
        probe(m_x + SQ - 1, m_y + SQ - 1, 1'b1, "sq_br");
        if (m_x + SQ < 640) probe(m_x + SQ, m_y + SQ - 1, 1'b1, "sq_right_out");
        if (m_y > 0) probe(m_x, m_y - 1, 1'b1, "sq_top_out");
        if (m_y + SQ < 480) probe(m_x, m_y + SQ, 1'b1, "sq_bot_out");
        probe($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)), "rand_px");
        go_idle(1);
    endtask

    // Monitor: every clock that carried stimulus yields one output to compare.
    initial begin
        logic [11:0] e;
        bit          k;
        string       nm;
        forever begin
            @(posedge clk_100MHz);
            if (req) begin
                #1;
                if (exp_q.size() == 0) begin
                    n_checks++; n_fail++;
                    $display("FAIL scoreboard_underflow: got output with empty queue");
                end else begin
                    e = exp_q.pop_front(); k = kind_q.pop_front(); nm = name_q.pop_front();
                    if (k) check(nm, {4'h0, bounce_cnt}, e);
                    else   check(nm, rgb, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int ox, oy;
        rst = 1'b1; pause = 1'b0; video = 1'b0; pixel_tick = 1'b0;
        pixel_x = 10'd700; pixel_y = 10'd500;
        model_reset();
        repeat (3) @(negedge clk_100MHz);
        check("reset_rgb", rgb, 12'h000);
        check("reset_cnt", {4'h0, bounce_cnt}, 12'h000);
        rst = 1'b0;

`ifdef VGA_BOUNCE_BORDER_EN
        probe_lit(8, 8, 12'hF00, "origin_sq");
        probe_lit(7, 8, 12'hFFF, "origin_left_border");
        probe_lit(3, 100, 12'hFFF, "border_3_100");
`else
        probe_lit(0, 0, 12'hF00, "origin_sq");
        probe_lit(32, 0, 12'h000, "origin_right_out");
        probe_lit(3, 100, 12'h000, "no_border_3_100");
`endif
        go_idle(1);

        refresh();
`ifndef VGA_BOUNCE_BORDER_EN
        probe_lit(2, 1, 12'hF00, "r1_2_1");
        probe_lit(1, 1, 12'h000, "r1_1_1");
        probe_lit(2, 0, 12'h000, "r1_2_0");
`endif
        probe_edges();

        for (int k = 2; k <= 460; k++) begin
            refresh();
`ifndef VGA_BOUNCE_BORDER_EN
            if (k == 304) begin
                cnt_lit(8'd1, "cnt_at_304");
                probe_lit(608, m_y, 12'hF00, "x608_in");
                probe_lit(607, m_y, 12'h000, "x607_out");
            end
            if (k == 305) begin
                probe_lit(606, m_y, 12'hF00, "x606_in");
                probe_lit(605, m_y, 12'h000, "x605_out");
            end
            if (k == 448) begin
                cnt_lit(8'd2, "cnt_at_448");
                probe_lit(m_x, 448, 12'hF00, "y448_in");
                probe_lit(m_x, 447, 12'h000, "y447_out");
            end
`endif
            if (k % 4 == 0 || k >= 300) probe_edges();
        end

        probe(m_x + 5, m_y + 5, 1'b0, "blank_in_sq");
        go_idle(1);

        pause = 1'b1;
        repeat (10) begin
            refresh();
            probe_edges();
        end
        pause = 1'b0;
        ox = m_x; oy = m_y;
        refresh();
        if (m_x == ox) begin
            n_checks++; n_fail++;
            $display("FAIL unpause_model: got x %0d expected movement", m_x);
        end
        probe_edges();
        probe_lit(ox, oy, (m_y == oy + 1 && (m_x == ox + 2 || m_x == ox - 2)) ? 12'h000 : 12'hF00,
                  "unpause_old_row");

        probe_lit(m_x + 1, m_y + 1, 12'hF00, "pre_rst_sq");
        @(posedge clk_100MHz);
        #2 rst = 1'b1;
        #1;
        check("midrst_rgb", rgb, 12'h000);
        check("midrst_cnt", {4'h0, bounce_cnt}, 12'h000);
        go_idle(2);
        rst = 1'b0;
        model_reset();
`ifdef VGA_BOUNCE_BORDER_EN
        probe_lit(8, 8, 12'hF00, "post_rst_origin");
        probe_lit(40, 8, 12'h000, "post_rst_right_out");
`else
        probe_lit(0, 0, 12'hF00, "post_rst_origin");
        probe_lit(32, 0, 12'h000, "post_rst_right_out");
`endif
        go_idle(1);
        refresh();
        probe_edges();

        for (int k = 0; k < 150; k++) begin
            pause = ($urandom_range(0, 3) == 0);
            refresh();
            probe_edges();
        end
        pause = 1'b0;

        go_idle(3);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
